pooled_uart_tx: RTL and testbench
=================================

# pooled_uart_tx

Serial output stage of the edge-detection pipeline: consumes 8-bit pooled pixels from the image-processing block over a valid/ready handshake and transmits each as an 8N1 UART frame on a single `tx` line. Sits directly downstream of the average-pooling output, in the 200 MHz processing domain. Its `ready_out` is the backpressure source for the whole pipeline. It also counts transmitted pixels and flags the end of each image frame.

## Interface
- `CLKS_PER_BIT`, default 1736: clocks per UART bit (200 MHz / 115200 baud); legal range ≥ 2.
- `FRAME_PIXELS`, default 16384: pixels per pooled image; legal range 1..65535.
- `clk_200mhz`  input  1  processing clock; every register is clocked on its rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-high.
- `pixel_in`  input  8  pooled pixel; sampled only on an accepting handshake.
- `valid_in`  input  1  `pixel_in` is valid.
- `ready_out`  output  1  block can accept a pixel this cycle.
- `tx`  output  1  UART serial line; idle high.
- `busy`  output  1  a byte is held or being shifted.
- `frame_done`  output  1  one-cycle pulse at the end of the last byte of a frame.
- `pixel_count`  output  16  bytes fully transmitted in the current frame.

## Operation
- Handshake: a transfer occurs on a rising edge where `valid_in && ready_out`. `ready_out` = !hold_full (registered state), so no combinational path from `valid_in`.
- Buffering: one-byte holding register plus one shift register. The holding register refills while the shifter is transmitting, which allows gapless back-to-back bytes.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if hold_full, load the shifter from the holding register, clear hold_full, and go to START. Otherwise stay.
  - START: `tx`=0 for CLKS_PER_BIT clocks, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT clocks. A 3-bit bit counter advances; after bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT clocks. At the end of STOP:
    - if hold_full, load the shifter, clear hold_full, and go directly to START (no idle cycle);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state change. Width is clog2(CLKS_PER_BIT).
- Load and accept never coincide: a load requires hold_full=1, which forces `ready_out`=0. A new accept is possible from the cycle after a load.
- `tx` is registered and driven from the FSM state and shifter LSB.
- `busy` = (state != IDLE) || hold_full.
- `pixel_count`: increments at the end of every STOP bit. When the increment would reach FRAME_PIXELS, it wraps to 0 and `frame_done` pulses high for exactly that cycle.
- Reset values: `tx`=1, `ready_out`=1, `busy`=0, `frame_done`=0, `pixel_count`=0; state IDLE; hold_full=0; all counters 0.
- Reset mid-byte: `tx` returns high asynchronously. Held and in-flight bytes are discarded and the frame count restarts at 0. No partial frame is completed after reset release.
- `pixel_in` changing or `valid_in` dropping without a handshake has no effect.

## Timing
- Accept edge at cycle N sets hold_full at N+1. The FSM loads at edge N+1, and `tx` goes low from cycle N+2 (2-cycle latency from accept to start bit).
- Frame on the wire: exactly 10×CLKS_PER_BIT clocks per byte (1 start, 8 data, 1 stop).
- With continuous `valid_in`, sustained throughput is one byte per 10×CLKS_PER_BIT clocks with no idle gap between stop and start bits.
- `ready_out` pattern under continuous `valid_in`:
  - high on the first accept cycle;
  - low for one cycle during the load;
  - high again until the second byte is accepted;
  - then low until the next load at the end of STOP.
- `frame_done` and the `pixel_count` update occur on the same edge that ends the stop bit.

## Test plan
- Single byte, CLKS_PER_BIT=4: send 0xA5 at cycle 0 → `tx` high through cycle 1. From cycle 2, `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clocks. `pixel_count`=1 and `busy`=0 after 40 clocks.
- Back-to-back, CLKS_PER_BIT=4: hold `valid_in` high with 0x00, 0xFF, 0x3C → 120 contiguous `tx` clocks with no high gap between stop and start bits. `ready_out` deasserts while the holding register is full.
- Backpressure ordering: present 5 bytes 0x11..0x55 with `valid_in` held high and `pixel_in` stable until accepted → bytes decoded from `tx` are exactly 0x11..0x55 in order, with no duplicates or drops.
- Frame wrap, FRAME_PIXELS=3: send 4 bytes → `frame_done` pulses once, at the end of the 3rd stop bit. `pixel_count` reads 1,2,0,1 after each byte.
- Reset mid-byte: assert `reset` during DATA bit 3 of 0x0F with a second byte held → `tx`=1 immediately, `busy`=0, `ready_out`=1. After release, no bits are emitted until a new byte is accepted.
- Idle: `valid_in`=0 for 1000 clocks after reset → `tx`=1, `busy`=0, `frame_done`=0 throughout.

Source files
------------

// File: rtl/pooled_uart_tx.sv
// ============================================================================
// Module   : pooled_uart_tx
// Purpose  : Accepts 8-bit pooled pixels over valid/ready and transmits each
//            one as an 8N1 UART frame. A one-byte holding register in front
//            of the shifter allows gapless back-to-back frames. Also counts
//            transmitted pixels per image and pulses at the end of each image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pooled_uart_tx #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int FRAME_PIXELS = 16384
) (
  input  logic        clk_200mhz,
  input  logic        reset,
  input  logic [7:0]  pixel_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pixel_count
);

  localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]       COUNT_LAST = 16'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          hold_reg;
  logic [7:0]          shift_reg;
  logic                hold_full;

  logic                accept;
  logic                bit_end;
  logic                load;

  // Backpressure comes straight from the holding-register flag, so ready_out
  // never depends combinationally on valid_in.
  assign ready_out = !hold_full;
  assign accept    = valid_in && !hold_full;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE) || hold_full;

  // The shifter takes the held byte either from IDLE or at the end of a stop
  // bit; both need hold_full, so a load can never coincide with an accept.
  assign load = hold_full &&
                ((state == IDLE) || ((state == STOP) && bit_end));

  // Holding register: filled on an accepting handshake, emptied on a load.
  always_ff @(posedge clk_200mhz or posedge reset) begin
    if (reset) begin
      hold_reg  <= 8'd0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= pixel_in;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame sequencer: baud timing, bit shifting, tx line and pixel counting.
  always_ff @(posedge clk_200mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'd0;
      tx          <= 1'b1;
      frame_done  <= 1'b0;
      pixel_count <= 16'd0;
    end else begin
      frame_done <= 1'b0;

      // tx is a registered image of the current state and shifter LSB
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (load) begin
            shift_reg <= hold_reg;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pixel_count == COUNT_LAST) begin
              pixel_count <= 16'd0;
              frame_done  <= 1'b1;
            end else begin
              pixel_count <= pixel_count + 16'd1;
            end
            // A byte already waiting goes straight out with no idle cycle
            if (load) begin
              shift_reg <= hold_reg;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pooled_uart_tx.sv
// ============================================================================
// Module   : tb_pooled_uart_tx
// Purpose  : Self-checking bench for pooled_uart_tx. A UART receiver model
//            decodes the tx line and compares against a queue of accepted
//            pixels; pixel/frame counts are derived from the number of
//            decoded bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pooled_uart_tx;

  localparam int CPB = 4;
  localparam int FP  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pixel_in = 8'd0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic [15:0] pixel_count;

  pooled_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FRAME_PIXELS (FP)
  ) dut (
    .clk_200mhz  (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .pixel_count (pixel_count)
  );

  always #2.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame_done pulses seen on the line (sampled once per cycle)
  int fd_count = 0;
  always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         dec_total = 0;
  int         dec_base  = 0;
  int         fd_base   = 0;
  bit         mon_en    = 1'b0;
  bit         mon_busy  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Receive one frame whose start bit was first seen at this negedge.
  task automatic decode_frame();
    logic [7:0] b;
    logic       st;
    logic       sp;
    int         dec;
    mon_busy = 1'b1;
    starts.push_back(cyc);
    repeat (CPB/2) @(negedge clk);
    st = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    sp = tx;
    repeat (CPB/2) @(negedge clk);
    check("start_bit", st, 1'b0);
    check("stop_bit", sp, 1'b1);
    check("frame_expected", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) check("data_byte", b, exp_q.pop_front());
    dec_total++;
    dec = dec_total - dec_base;
    check("pixel_count", pixel_count, dec % FP);
    check("frame_done_pulses", fd_count - fd_base, dec / FP);
    mon_busy = 1'b0;
  endtask

  task automatic mon_loop();
    forever begin
      if (mon_en && tx === 1'b0 && reset === 1'b0) decode_frame();
      else @(negedge clk);
    end
  endtask

  // Present a byte from a negedge until accepted; returns at the negedge
  // following the accepting edge.
  task automatic send(input logic [7:0] d, input bit keep_valid);
    int n;
    n        = 0;
    valid_in = 1'b1;
    pixel_in = d;
    while (ready_out !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", n < 1000, 1'b1);
    exp_q.push_back(d);
    @(negedge clk);
    if (!keep_valid) begin
      valid_in = 1'b0;
      pixel_in = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < 3000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s0;
    int bad_tx;
    int bad_busy;
    int bad_fd;

    fork
      mon_loop();
    join_none

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_pixel_count", pixel_count, 16'd0);
    reset    = 1'b0;
    fd_base  = fd_count;
    dec_base = dec_total;
    mon_en   = 1'b1;

    // Idle with random pixel_in and no valid
    bad_tx = 0; bad_busy = 0; bad_fd = 0;
    repeat (1000) begin
      @(negedge clk);
      pixel_in = 8'($urandom);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (frame_done !== 1'b0) bad_fd++;
    end
    check("idle_tx_low_cycles", bad_tx, 0);
    check("idle_busy_cycles", bad_busy, 0);
    check("idle_frame_done_cycles", bad_fd, 0);

    // Single byte: two-cycle latency from accept to start bit
    send(8'hA5, 1'b0);
    check("latency_c0_tx", tx, 1'b1);
    @(negedge clk);
    check("latency_c1_tx", tx, 1'b1);
    @(negedge clk);
    check("latency_c2_tx", tx, 1'b0);
    drain();
    check("single_busy", busy, 1'b0);
    check("single_count", pixel_count, 16'd1);

    // Back-to-back with valid held high
    s0 = starts.size();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    check("hold_full_ready", ready_out, 1'b0);
    send(8'h3C, 1'b1);
    valid_in = 1'b0;
    drain();
    check("b2b_frames", starts.size() - s0, 3);
    for (int k = 1; k < 3; k++)
      check("b2b_gapless", starts[s0+k] - starts[s0+k-1], 10*CPB);

    // Backpressure ordering 0x11..0x55
    s0 = starts.size();
    for (int k = 1; k <= 5; k++) send(8'(k * 8'h11), 1'b1);
    valid_in = 1'b0;
    drain();
    check("bp_frames", starts.size() - s0, 5);
    for (int k = 1; k < 5; k++)
      check("bp_gapless", starts[s0+k] - starts[s0+k-1], 10*CPB);

    // Random traffic with random idle gaps
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 50)) begin
        @(negedge clk);
        pixel_in = 8'($urandom);
      end
      send(8'($urandom), 1'b0);
    end
    drain();

    // Reset during data bit 3 of 0x0F with a second byte held
    mon_en = 1'b0;
    send(8'h0F, 1'b0);
    send(8'h99, 1'b0);
    repeat (16) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", ready_out, 1'b1);
    check("midrst_count", pixel_count, 16'd0);
    check("midrst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    fd_base  = fd_count;
    dec_base = dec_total;
    bad_tx = 0; bad_busy = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("post_reset_tx_low_cycles", bad_tx, 0);
    check("post_reset_busy_cycles", bad_busy, 0);
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) send(8'($urandom), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #250000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
